// File: rtl/quiz_pkg.sv
// Shared definitions for the arithmetic quiz game: answer/operator codes,
// answer_input FSM states and small bit-vector helpers.
package quiz_pkg;

  localparam logic [1:0] ANS_ADD  = 2'd0;
  localparam logic [1:0] ANS_SUB  = 2'd1;
  localparam logic [1:0] ANS_MUL  = 2'd2;
  localparam logic [1:0] ANS_PASS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  function automatic logic [2:0] count_ones(input logic [3:0] v);
    count_ones = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Answer code for a vector with exactly one bit set; bit order matches the codes.
  function automatic logic [1:0] press_code(input logic [3:0] v);
    unique case (1'b1)
      v[1]:    press_code = ANS_SUB;
      v[2]:    press_code = ANS_MUL;
      v[3]:    press_code = ANS_PASS;
      default: press_code = ANS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One-bit switch conditioner: two-flop synchroniser followed by a
// consecutive-sample debounce counter that holds the clean level.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic [CW-1:0] cnt;

  // Any cycle where the synchronised input agrees with the held level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/answer_input.sv
// Player answer input: debounces four switches, emits one token per clean
// press over valid/ready, then locks out until every switch is released.
module answer_input
  import quiz_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switch,
  input  logic       ans_ready,
  output logic       ans_valid,
  output logic [1:0] ans_code,
  output logic       multi_err,
  output logic [3:0] sw_db
);

  state_t     state;
  logic [3:0] sw_db_d;
  logic [3:0] press;
  logic [2:0] press_cnt;

  for (genvar i = 0; i < 4; i++) begin : g_db
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (switch[i]),
      .level(sw_db[i])
    );
  end

  assign press     = sw_db & ~sw_db_d;
  assign press_cnt = count_ones(press);

  // Presses outside IDLE are deliberately dropped; RELEASE only exits once all levels are low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sw_db_d   <= 4'b0000;
      ans_valid <= 1'b0;
      ans_code  <= ANS_ADD;
      multi_err <= 1'b0;
    end else begin
      sw_db_d   <= sw_db;
      multi_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press_cnt == 3'd1) begin
            ans_code  <= press_code(press);
            ans_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (press_cnt > 3'd1) begin
            multi_err <= 1'b1;
            state     <= S_RELEASE;
          end
        end
        S_HOLD: begin
          if (ans_ready) begin
            ans_valid <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (sw_db == 4'b0000) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
